// File: rtl/pipe_scheduler_pkg.sv
// Shared definitions for the pipe scheduler: FSM encoding, pipe word layout
// and the LFSR feedback mask.
package pipe_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP0,
    ST_STEP1,
    ST_STEP2,
    ST_FROZEN,
    ST_REINIT
  } state_t;

  localparam int HEIGHT_LSB = 0;
  localparam int X_LSB      = 10;
  localparam int GAP_LSB    = 20;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/pipe_scheduler_bcd_counter4.sv
// Four-digit BCD counter with synchronous clear and an increment that
// saturates at 9999.
module bcd_counter4 (
  input  logic        clk,
  input  logic        clrn,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != 16'h9999)) begin
      cnt <= bcd_inc(cnt);
    end
  end

endmodule

// File: rtl/pipe_scheduler.sv
// Scrolls and recycles three pipe groups once per frame tick, one pipe per
// cycle, and scores the player passing each pipe.
module pipe_scheduler
  import pipe_scheduler_pkg::*;
#(
  parameter int          SCREEN_W = 640,
  parameter int          SPACING  = 180,
  parameter int          SPEED    = 2,
  parameter int          X_MARIO  = 40,
  parameter int          H_MIN    = 60,
  parameter int          GAP_MIN  = 120,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic        f_tick,
  input  logic        fail,
  output logic [31:0] pipe_1,
  output logic [31:0] pipe_2,
  output logic [31:0] pipe_3,
  output logic [15:0] score,
  output logic        pass,
  output logic        busy
);

  localparam logic [9:0] SPEED_W   = 10'(SPEED);
  localparam logic [9:0] WRAP_ADD  = 10'((3 * SPACING) % 1024);
  localparam logic [9:0] H_MIN_W   = 10'(H_MIN);
  localparam logic [9:0] X_MARIO_W = 10'(X_MARIO);
  localparam logic [7:0] GAP_MIN_W = 8'(GAP_MIN);

  function automatic logic [31:0] init_pipe(input int i);
    logic [31:0] w;
    w                     = '0;
    w[HEIGHT_LSB +: 10]   = 10'(H_MIN + 40 * i);
    w[X_LSB +: 10]        = 10'(SCREEN_W + i * SPACING);
    w[GAP_LSB +: 8]       = GAP_MIN_W;
    return w;
  endfunction

  state_t      state;
  logic [31:0] pipe [3];
  logic [15:0] lfsr;

  logic [1:0]  k;
  logic [9:0]  x_old;
  logic [9:0]  x_new;
  logic [9:0]  h_new;
  logic [7:0]  g_new;
  logic        recycle;
  logic        hit;
  logic        stepping;
  logic        step_go;
  logic [31:0] word_new;

  assign stepping = (state == ST_STEP0) || (state == ST_STEP1) || (state == ST_STEP2);
  assign step_go  = stepping && !fail;
  assign busy     = stepping;

  assign pipe_1 = pipe[0];
  assign pipe_2 = pipe[1];
  assign pipe_3 = pipe[2];

  always_comb begin
    case (state)
      ST_STEP1: k = 2'd1;
      ST_STEP2: k = 2'd2;
      default:  k = 2'd0;
    endcase
    x_old   = pipe[k][X_LSB +: 10];
    h_new   = pipe[k][HEIGHT_LSB +: 10];
    g_new   = pipe[k][GAP_LSB +: 8];
    recycle = x_old < SPEED_W;
    // Recycled pipe reappears one full loop (three spacings) to the right.
    if (recycle) begin
      x_new = x_old - SPEED_W + WRAP_ADD;
      h_new = H_MIN_W + {2'b00, lfsr[7:0]};
      g_new = GAP_MIN_W + {2'b00, lfsr[13:10], 2'b00};
    end else begin
      x_new = x_old - SPEED_W;
    end
    hit      = !recycle && (x_old > X_MARIO_W) && (x_new <= X_MARIO_W);
    word_new = '0;
    word_new[HEIGHT_LSB +: 10] = h_new;
    word_new[X_LSB +: 10]      = x_new;
    word_new[GAP_LSB +: 8]     = g_new;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      lfsr <= SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= ST_IDLE;
      pass  <= 1'b0;
      for (int i = 0; i < 3; i++) pipe[i] <= init_pipe(i);
    end else begin
      pass <= 1'b0;
      case (state)
        ST_IDLE: if (start) state <= ST_RUN;
        ST_RUN: begin
          if (fail)        state <= ST_FROZEN;
          else if (f_tick) state <= ST_STEP0;
        end
        ST_STEP0, ST_STEP1, ST_STEP2: begin
          // A fail mid-step leaves the current and later pipes untouched.
          if (fail) begin
            state <= ST_FROZEN;
          end else begin
            pipe[k] <= word_new;
            pass    <= hit;
            case (state)
              ST_STEP0: state <= ST_STEP1;
              ST_STEP1: state <= ST_STEP2;
              default:  state <= ST_RUN;
            endcase
          end
        end
        ST_FROZEN: if (start) state <= ST_REINIT;
        ST_REINIT: begin
          for (int i = 0; i < 3; i++) pipe[i] <= init_pipe(i);
          state <= ST_RUN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bcd_counter4 u_score (
    .clk  (clk),
    .clrn (clrn),
    .clr  (state == ST_REINIT),
    .inc  (step_go && hit),
    .cnt  (score)
  );

endmodule
